// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit.
// Radix-2 shift-add multiplier and restoring divider sharing one 2*WIDTH
// working register; the datapath is stalled through oStall until the
// result is ready. Divide-by-zero and signed overflow finish in one cycle.
module muldiv_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iStart,
    input  logic [4:0]       iALUControl,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    output logic [WIDTH-1:0] oResult,
    output logic             oBusy,
    output logic             oDone,
    output logic             oStall
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    // ALU control codes shared with the uniciclo control block
    localparam logic [4:0] OPMUL    = 5'd11;
    localparam logic [4:0] OPMULH   = 5'd12;
    localparam logic [4:0] OPMULHSU = 5'd13;
    localparam logic [4:0] OPMULHU  = 5'd14;
    localparam logic [4:0] OPDIV    = 5'd15;
    localparam logic [4:0] OPDIVU   = 5'd16;
    localparam logic [4:0] OPREM    = 5'd17;
    localparam logic [4:0] OPREMU   = 5'd18;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q;
    logic [4:0]       op_q;
    logic [WIDTH-1:0] mcand_q;      // multiplicand or divisor magnitude
    logic [PW-1:0]    prod_q;       // product, or {remainder, dividend/quotient}
    logic [CW-1:0]    cnt_q;
    logic             neg_q;        // sign of product / quotient
    logic             neg_rem_q;    // sign of remainder
    logic [WIDTH-1:0] result_q;
    logic             busy_q;
    logic             done_q;

    logic             is_m_c;
    logic             is_div_c;
    logic             sign_a_c;
    logic             sign_b_c;
    logic [WIDTH-1:0] a_mag_c;
    logic [WIDTH-1:0] b_mag_c;
    logic             div_zero_c;
    logic             div_ovf_c;
    logic [WIDTH-1:0] special_c;

    logic [PW-1:0]    prod_d;
    logic [WIDTH:0]   mul_sum_c;
    logic [WIDTH:0]   div_trial_c;
    logic [WIDTH:0]   div_diff_c;
    logic [PW-1:0]    mul_full_c;
    logic [WIDTH-1:0] quo_c;
    logic [WIDTH-1:0] rem_c;
    logic [WIDTH-1:0] res_fin_c;
    logic             last_c;

    // Decode the request and form operand magnitudes and special-case results
    always_comb begin
        is_m_c   = 1'b0;
        is_div_c = 1'b0;
        sign_a_c = 1'b0;
        sign_b_c = 1'b0;
        unique case (iALUControl)
            OPMUL, OPMULH: begin
                is_m_c   = 1'b1;
                sign_a_c = iA[WIDTH-1];
                sign_b_c = iB[WIDTH-1];
            end
            OPMULHSU: begin
                is_m_c   = 1'b1;
                sign_a_c = iA[WIDTH-1];
            end
            OPMULHU: is_m_c = 1'b1;
            OPDIV, OPREM: begin
                is_m_c   = 1'b1;
                is_div_c = 1'b1;
                sign_a_c = iA[WIDTH-1];
                sign_b_c = iB[WIDTH-1];
            end
            OPDIVU, OPREMU: begin
                is_m_c   = 1'b1;
                is_div_c = 1'b1;
            end
            default: ;
        endcase
        a_mag_c    = sign_a_c ? (~iA + WIDTH'(1)) : iA;
        b_mag_c    = sign_b_c ? (~iB + WIDTH'(1)) : iB;
        div_zero_c = (iB == '0);
        div_ovf_c  = ((iALUControl == OPDIV) || (iALUControl == OPREM)) &&
                     (iA == MIN_NEG) && (iB == '1);
        if (div_zero_c) begin
            special_c = ((iALUControl == OPDIV) || (iALUControl == OPDIVU)) ? '1 : iA;
        end else begin
            special_c = (iALUControl == OPDIV) ? MIN_NEG : '0;
        end
    end

    // One shift-add or restoring-division step, plus final sign fix-up
    always_comb begin
        mul_sum_c   = {1'b0, prod_q[PW-1:WIDTH]} +
                      (prod_q[0] ? {1'b0, mcand_q} : '0);
        div_trial_c = prod_q[PW-1:WIDTH-1];
        div_diff_c  = div_trial_c - {1'b0, mcand_q};
        prod_d      = prod_q;
        if (state_q == S_MUL) begin
            prod_d = {mul_sum_c, prod_q[WIDTH-1:1]};
        end else if (state_q == S_DIV) begin
            if (!div_diff_c[WIDTH]) begin
                prod_d = {div_diff_c[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
            end else begin
                prod_d = {div_trial_c[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
            end
        end
        mul_full_c = neg_q ? (~prod_d + PW'(1)) : prod_d;
        quo_c      = neg_q ? (~prod_d[WIDTH-1:0] + WIDTH'(1)) : prod_d[WIDTH-1:0];
        rem_c      = neg_rem_q ? (~prod_d[PW-1:WIDTH] + WIDTH'(1)) : prod_d[PW-1:WIDTH];
        unique case (op_q)
            OPMUL:          res_fin_c = mul_full_c[WIDTH-1:0];
            OPDIV, OPDIVU:  res_fin_c = quo_c;
            OPREM, OPREMU:  res_fin_c = rem_c;
            default:        res_fin_c = mul_full_c[PW-1:WIDTH];
        endcase
        last_c = (cnt_q == CW'(WIDTH - 1));
    end

    // Control FSM with registered result and status outputs
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            mcand_q   <= '0;
            prod_q    <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (iStart && is_m_c) begin
                        op_q  <= iALUControl;
                        cnt_q <= '0;
                        if (is_div_c && (div_zero_c || div_ovf_c)) begin
                            state_q  <= S_DONE;
                            result_q <= special_c;
                            done_q   <= 1'b1;
                        end else begin
                            state_q   <= is_div_c ? S_DIV : S_MUL;
                            busy_q    <= 1'b1;
                            mcand_q   <= is_div_c ? b_mag_c : a_mag_c;
                            prod_q    <= {{WIDTH{1'b0}}, (is_div_c ? a_mag_c : b_mag_c)};
                            neg_q     <= sign_a_c ^ sign_b_c;
                            neg_rem_q <= sign_a_c;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    prod_q <= prod_d;
                    cnt_q  <= cnt_q + CW'(1);
                    if (last_c) begin
                        state_q  <= S_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= res_fin_c;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign oResult = result_q;
    assign oBusy   = busy_q;
    assign oDone   = done_q;

    // Hold PC and register write from the accepting cycle until DONE
    assign oStall = ~iRST & ((state_q == S_IDLE && iStart && is_m_c) ||
                             (state_q == S_MUL) || (state_q == S_DIV));

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomised and directed bench for muldiv_seq against an arithmetic model.
module tb_muldiv_seq;

    localparam logic [4:0] OPADD    = 5'd3;
    localparam logic [4:0] OPMUL    = 5'd11;
    localparam logic [4:0] OPMULH   = 5'd12;
    localparam logic [4:0] OPMULHSU = 5'd13;
    localparam logic [4:0] OPMULHU  = 5'd14;
    localparam logic [4:0] OPDIV    = 5'd15;
    localparam logic [4:0] OPDIVU   = 5'd16;
    localparam logic [4:0] OPREM    = 5'd17;
    localparam logic [4:0] OPREMU   = 5'd18;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iStart;
    logic [4:0]  iALUControl;
    logic [31:0] iA;
    logic [31:0] iB;
    logic [31:0] oResult;
    logic        oBusy;
    logic        oDone;
    logic        oStall;

    int checks   = 0;
    int failures = 0;

    muldiv_seq #(.WIDTH(32)) dut (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .iStart     (iStart),
        .iALUControl(iALUControl),
        .iA         (iA),
        .iB         (iB),
        .oResult    (oResult),
        .oBusy      (oBusy),
        .oDone      (oDone),
        .oStall     (oStall)
    );

    always #5 iCLK = ~iCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // RV32M semantics from plain 64-bit arithmetic
    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ua;
        logic [63:0] p;
        logic [63:0] pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        pu = {32'b0, a} * {32'b0, b};
        case (op)
            OPMUL:    begin p = 64'(sa * sb); return p[31:0];  end
            OPMULH:   begin p = 64'(sa * sb); return p[63:32]; end
            OPMULHSU: begin p = 64'(sa * longint'({32'b0, b})); return p[63:32]; end
            OPMULHU:  return pu[63:32];
            OPDIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = 64'(sa / sb); return p[31:0];
            end
            OPREM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = 64'(sa % sb); return p[31:0];
            end
            OPDIVU: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = 64'(ua / longint'({32'b0, b})); return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = 64'(ua % longint'({32'b0, b})); return p[31:0];
            end
        endcase
    endfunction

    function automatic int exp_latency(input logic [4:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        bit is_div;
        is_div = (op == OPDIV) || (op == OPDIVU) || (op == OPREM) || (op == OPREMU);
        if (is_div && b == 0) return 1;
        if ((op == OPDIV || op == OPREM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return 1;
        return 33;
    endfunction

    // Issue one op, scramble inputs while busy, and check timing and result
    task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int glitch_cyc, input string tag);
        logic [31:0] exp;
        int          lat;
        int          cyc;
        exp = model(op, a, b);
        lat = exp_latency(op, a, b);
        @(negedge iCLK);
        iStart = 1'b1; iALUControl = op; iA = a; iB = b;
        #1 check({tag, "_stall_T"}, 32'(oStall), 32'd1);
        @(posedge iCLK);
        #1;
        iStart = 1'b0; iA = $urandom; iB = $urandom;
        cyc = 1;
        while (!oDone && cyc < 40) begin
            if (cyc == 1 || cyc == lat - 1) begin
                check({tag, "_busy"}, 32'(oBusy), 32'd1);
                check({tag, "_stall"}, 32'(oStall), 32'd1);
            end
            iStart = (cyc == glitch_cyc);
            iALUControl = OPDIV;
            iA = $urandom; iB = $urandom;
            @(posedge iCLK);
            #1;
            cyc++;
        end
        iStart = 1'b0;
        check({tag, "_lat"}, 32'(cyc), 32'(lat));
        check({tag, "_res"}, oResult, exp);
        check({tag, "_done_stall"}, {30'b0, oBusy, oStall}, 32'd0);
        @(posedge iCLK);
        #1;
        check({tag, "_done_pulse"}, 32'(oDone), 32'd0);
        check({tag, "_hold"}, oResult, exp);
    endtask

    logic [4:0]  ops [8] = '{OPMUL, OPMULH, OPMULHSU, OPMULHU, OPDIV, OPDIVU, OPREM, OPREMU};
    logic [31:0] prev;

    initial begin
        iRST = 1'b1; iStart = 1'b0; iALUControl = '0; iA = '0; iB = '0;
        repeat (2) @(posedge iCLK);
        #1;
        check("rst_out", {oResult[31:3], oBusy, oDone, oStall}, 32'd0);
        check("rst_res", oResult, 32'd0);
        @(negedge iCLK);
        iRST = 1'b0;

        do_op(OPMUL,    32'd7,          32'hFFFF_FFFD, 0,  "mul_neg");
        do_op(OPMULH,   32'h8000_0000,  32'h8000_0000, 0,  "mulh");
        do_op(OPMULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 0,  "mulhu");
        do_op(OPMULHSU, 32'hFFFF_FFFF,  32'd2,         0,  "mulhsu");
        do_op(OPDIV,    32'hFFFF_FFF9,  32'd2,         0,  "div_neg");
        do_op(OPREM,    32'hFFFF_FFF9,  32'd2,         0,  "rem_neg");
        do_op(OPDIVU,   32'd100,        32'd7,         0,  "divu");
        do_op(OPREMU,   32'd100,        32'd7,         0,  "remu");
        do_op(OPDIVU,   32'd5,          32'd0,         0,  "divu_z");
        do_op(OPREM,    32'd5,          32'd0,         0,  "rem_z");
        do_op(OPDIV,    32'h8000_0000,  32'hFFFF_FFFF, 0,  "div_ovf");
        do_op(OPREM,    32'h8000_0000,  32'hFFFF_FFFF, 0,  "rem_ovf");
        do_op(OPMUL,    32'd12345,      32'd678,       10, "mul_glitch");

        // Non-M code is ignored
        prev = oResult;
        @(negedge iCLK);
        iStart = 1'b1; iALUControl = OPADD; iA = 32'd1; iB = 32'd2;
        #1 check("add_stall", 32'(oStall), 32'd0);
        @(posedge iCLK);
        #1;
        check("add_busy", {30'b0, oBusy, oDone}, 32'd0);
        check("add_res", oResult, prev);
        iStart = 1'b0;

        // Reset in the middle of a divide
        @(negedge iCLK);
        iStart = 1'b1; iALUControl = OPDIV; iA = 32'd1000; iB = 32'd3;
        repeat (10) @(posedge iCLK);
        #1;
        iStart = 1'b0;
        check("pre_rst_busy", 32'(oBusy), 32'd1);
        iRST = 1'b1;
        #1;
        check("mid_rst", {oResult[31:2], oBusy, oStall}, 32'd0);
        check("mid_rst_res", oResult, 32'd0);
        @(negedge iCLK);
        iRST = 1'b0;
        do_op(OPDIVU, 32'd100, 32'd7, 0, "post_rst");

        // Random operations including forced special cases
        for (int n = 0; n < 48; n++) begin
            logic [4:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = ops[$urandom_range(0, 7)];
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 15))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 9));
                3: a = 32'($urandom_range(0, 50));
                default: ;
            endcase
            do_op(op, a, b, 0, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative RV32M multiply/divide unit sitting directly downstream of the uniciclo control block, beside the integer ALU.
- Consumes the 5-bit ALU control code (OPMUL..OPREMU from Parametros.v) together with both register operands.
- Computes the result over multiple cycles and drives a stall so the PC and register file hold until the result is ready.
- All non-M ALU codes are ignored and remain handled by the combinational ALU.

Parameters:
WIDTH, 32, operand and result width in bits; the iteration count equals WIDTH.

Ports:
iCLK  input  1  system clock; all state updates on the rising edge.
iRST  input  1  reset, asynchronous, active-high.
iStart  input  1  request: the current instruction is an M-extension op (asserted by the datapath while opcode is RTYPE with Funct7 MULDIV).
iALUControl  input  5  ALU control code; only OPMUL, OPMULH, OPMULHSU, OPMULHU, OPDIV, OPDIVU, OPREM, OPREMU are accepted.
iA  input  WIDTH  rs1 operand (dividend / multiplicand).
iB  input  WIDTH  rs2 operand (divisor / multiplier).
oResult  output  WIDTH  result; valid while oDone=1 and held until the next accepted start.
oBusy  output  1  registered; high while an operation is in progress.
oDone  output  1  registered; one-cycle pulse when oResult becomes valid.
oStall  output  1  combinational; holds the PC and blocks the register write.

Behaviour:
- Reset (asynchronous, iRST=1): state=IDLE; oResult=0, oBusy=0, oDone=0, oStall=0; all internal registers cleared.
- States and transitions:
  - IDLE -> MUL or DIV when iStart=1 and iALUControl is a valid M code.
  - DIV -> DONE in one cycle on the special cases below.
  - MUL/DIV -> DONE after WIDTH iterations.
  - DONE -> IDLE unconditionally after one cycle.
- Accept: sampled on the edge of cycle T while in IDLE.
  - iStart=1 with a non-M code: ignored; stays IDLE; oStall=0.
- Operand capture at accept:
  - Signed ops convert to magnitudes and record the result sign.
  - MULH: both operands signed. MULHSU: iA signed, iB unsigned. MULHU/DIVU/REMU: both unsigned.
- MUL path:
  - Radix-2 shift-add into a 2*WIDTH product register, one bit per cycle during cycles T+1..T+WIDTH.
  - Sign fix-up (two's complement of the 64-bit product when the sign is negative) is applied on entry to DONE.
  - MUL returns the low word; MULH/MULHSU/MULHU return the high word.
- DIV path:
  - Restoring division, one quotient bit per cycle during T+1..T+WIDTH.
  - Quotient sign = signA XOR signB; remainder sign = signA.
- Latency:
  - Normal ops: oDone=1 in cycle T+WIDTH+1 (T+33 at default WIDTH).
  - oBusy=1 in cycles T+1..T+WIDTH.
- Special cases, resolved without iterating; DONE is reached at T+1:
  - Divide by zero: DIV/DIVU -> all ones (0xFFFFFFFF); REM/REMU -> iA.
  - Signed overflow (iA=0x80000000, iB=0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
- oStall = (state==IDLE & iStart & valid code) | state==MUL | state==DIV.
  - oStall is low in DONE, so the datapath writes oResult to rd and advances the PC in that cycle.
- Inputs changing while busy: ignored, because operands are captured at accept.
- iStart held high in DONE: no new accept until IDLE is reached. A back-to-back op is accepted in the cycle after DONE.
- Reset mid-operation: immediate return to IDLE with all outputs 0. The next start behaves normally.

Test Plan:
- MUL iA=7, iB=0xFFFFFFFD (-3), start at T -> oDone=1 at T+33, oResult=0xFFFFFFEB; oBusy=1 at T+1..T+32; oStall=1 at T..T+32 and 0 at T+33.
- MULH iA=iB=0x80000000 -> oResult=0x40000000. MULHU iA=iB=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU iA=0xFFFFFFFF, iB=2 -> 0xFFFFFFFF.
- DIV iA=0xFFFFFFF9 (-7), iB=2 -> oResult=0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF. DIVU iA=100, iB=7 -> 14. REMU -> 2.
- DIVU iA=5, iB=0 -> oDone at T+1, oResult=0xFFFFFFFF. REM iA=5, iB=0 -> 5. DIV iA=0x80000000, iB=0xFFFFFFFF -> 0x80000000 at T+1.
- iStart=1 with OPADD -> stays IDLE; oStall=0, oBusy=0, oResult unchanged. A second iStart during MUL iteration 10 is ignored; the first result is correct at T+33.
- Assert iRST at T+10 of a DIV -> the same cycle shows oBusy=0, oStall=0, oResult=0. A following DIVU 100/7 returns 14 at 33 cycles after its start.
